// File: rtl/pic_host_sequencer.sv
// rtl/pic_host_sequencer.sv - 8259A host sequencer: init writes, two-pulse INTA, EOI.
// Optional PIC_SEQ_SPECIFIC_EOI_EN: specific EOI from vector[2:0] instead of 8'h20.
module pic_host_sequencer #(
  parameter logic [7:0] ICW1_VAL      = 8'h13,
  parameter logic [7:0] ICW2_VAL      = 8'hA8,
  parameter logic [7:0] ICW3_VAL      = 8'h00,
  parameter logic [7:0] ICW4_VAL      = 8'h01,
  parameter logic [7:0] OCW1_VAL      = 8'h00,
  parameter int         STROBE_CYCLES = 2,
  parameter int         GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       svc_done,
  output logic       busy,
  output logic       init_done,
  output logic       chip_select,
  output logic       write_enable,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       INT,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       in_service
);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, W_NEXT, READY, INTA1, INTA_GAP, INTA2, WAIT_SVC
  } state_t;

  // AEOI only takes effect if ICW4 is actually written
  localparam logic        AEOI        = ICW1_VAL[0] & ICW4_VAL[1];
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_WORD   = 3'd4;

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [2:0]  word_idx;
  logic        is_eoi;
  logic        start_ok;
  logic [7:0]  eoi_word;

  function automatic logic [7:0] word_for(input logic [2:0] idx);
    case (idx)
      3'd0:    word_for = ICW1_VAL;
      3'd1:    word_for = ICW2_VAL;
      3'd2:    word_for = ICW3_VAL;
      3'd3:    word_for = ICW4_VAL;
      default: word_for = OCW1_VAL;
    endcase
  endfunction

  // Word order ICW1, ICW2, ICW3, ICW4, OCW1 with disabled words skipped
  function automatic logic [2:0] next_word(input logic [2:0] idx);
    next_word = idx + 3'd1;
    if (next_word == 3'd2 && ICW1_VAL[1])  next_word = 3'd3;
    if (next_word == 3'd3 && !ICW1_VAL[0]) next_word = 3'd4;
  endfunction

`ifdef PIC_SEQ_SPECIFIC_EOI_EN
  assign eoi_word = {5'b01100, vector[2:0]};
`else
  assign eoi_word = 8'h20;
`endif

  assign start_ok = start && (state == IDLE || state == READY);

  always_comb begin
    state_n      = state;
    chip_select  = 1'b1;
    write_enable = 1'b1;
    data_oe      = 1'b0;
    INTA         = 1'b1;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = W_SETUP;
      end
      W_SETUP: begin
        chip_select = 1'b0;
        data_oe     = 1'b1;
        state_n     = W_STROBE;
      end
      W_STROBE: begin
        chip_select  = 1'b0;
        data_oe      = 1'b1;
        write_enable = 1'b0;
        if (cnt == STROBE_LAST) state_n = W_HOLD;
      end
      W_HOLD: begin
        chip_select = 1'b0;
        data_oe     = 1'b1;
        state_n     = W_NEXT;
      end
      W_NEXT: begin
        if (is_eoi || word_idx == LAST_WORD) state_n = READY;
        else                                 state_n = W_SETUP;
      end
      READY: begin
        busy = 1'b0;
        if (start)                 state_n = W_SETUP;
        else if (INT && init_done) state_n = INTA1;
      end
      INTA1: begin
        INTA = 1'b0;
        if (cnt == STROBE_LAST) state_n = INTA_GAP;
      end
      INTA_GAP: begin
        if (cnt == GAP_LAST) state_n = INTA2;
      end
      INTA2: begin
        INTA = 1'b0;
        if (cnt == STROBE_LAST) state_n = AEOI ? READY : WAIT_SVC;
      end
      WAIT_SVC: begin
        busy = 1'b0;
        if (svc_done) state_n = W_SETUP;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      word_idx     <= '0;
      is_eoi       <= 1'b0;
      A0           <= 1'b0;
      data_out     <= '0;
      vector       <= '0;
      vector_valid <= 1'b0;
      in_service   <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (state_n != state) ? '0 : cnt + 16'd1;
      vector_valid <= 1'b0;
      if (start_ok) begin
        word_idx  <= '0;
        data_out  <= ICW1_VAL;
        A0        <= 1'b0;
        is_eoi    <= 1'b0;
        init_done <= 1'b0;
      end
      case (state)
        W_NEXT: begin
          if (state_n == W_SETUP) begin
            word_idx <= next_word(word_idx);
            data_out <= word_for(next_word(word_idx));
            A0       <= 1'b1;
          end else if (is_eoi) begin
            is_eoi     <= 1'b0;
            in_service <= 1'b0;
          end else begin
            init_done <= 1'b1;
          end
        end
        INTA2: begin
          if (state_n != INTA2) begin
            vector       <= data_in;
            vector_valid <= 1'b1;
            in_service   <= !AEOI;
          end
        end
        WAIT_SVC: begin
          if (svc_done) begin
            is_eoi   <= 1'b1;
            data_out <= eoi_word;
            A0       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
